// File: rtl/key_field_editor.sv
// Debounced five-key editor for NFIELD packed FW-bit fields with per-field min/max wrap.
// Optional auto-repeat of UP/DOWN while editing is enabled by defining KEY_FIELD_EDITOR_REPEAT_EN.
module key_field_editor #(
    parameter int NFIELD       = 3,
    parameter int FW           = 7,
    parameter int FSW          = 2,
    parameter int DEBOUNCE_CYC = 150,
    parameter int REPEAT_DLY   = 1500,
    parameter int REPEAT_RATE  = 300
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [4:0]           KEY,
    input  logic [NFIELD*FW-1:0] IN_VAL,
    input  logic [NFIELD*FW-1:0] MIN_VAL,
    input  logic [NFIELD*FW-1:0] MAX_VAL,
    output logic [NFIELD*FW-1:0] OUT_VAL,
    output logic [FSW-1:0]       FIELD_SEL,
    output logic                 EDITING,
    output logic                 COMMIT
);
    localparam int DW    = NFIELD * FW;
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [4:0] K_MENU   = 5'b10000;
    localparam logic [4:0] K_SET    = 5'b01000;
    localparam logic [4:0] K_CANCEL = 5'b00100;
    localparam logic [4:0] K_UP     = 5'b00010;
    localparam logic [4:0] K_DOWN   = 5'b00001;

    typedef enum logic {ST_IDLE, ST_EDIT} state_t;

    state_t            r_state;
    logic [4:0]        r_code;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_evt;
    logic [4:0]        r_evt_key;
    logic [DW-1:0]     r_out;
    logic [FSW-1:0]    r_sel;
    logic              r_commit;

    logic              w_key_ok;
    logic              w_same;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_press;
    logic              w_fire;
    logic [FW-1:0]     w_cur;
    logic [FW-1:0]     w_min;
    logic [FW-1:0]     w_max;
    logic [FW-1:0]     w_up;
    logic [FW-1:0]     w_dn;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        w_key_ok  = $onehot(KEY);
        w_same    = w_key_ok && (KEY == r_code);
        w_cnt_nxt = '0;
        if (w_key_ok) begin
            if (!w_same)
                w_cnt_nxt = CNT_W'(1);
            else if (r_cnt == CNT_W'(DEBOUNCE_CYC))
                w_cnt_nxt = r_cnt;
            else
                w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // The counter saturates after acceptance, so a held key cannot fire again.
        w_press = w_key_ok && (w_cnt_nxt == CNT_W'(DEBOUNCE_CYC))
                  && !(w_same && (r_cnt == CNT_W'(DEBOUNCE_CYC)));
    end

`ifdef KEY_FIELD_EDITOR_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt;
    logic             r_rpt_first;
    logic             w_rpt_hold;
    logic [RPT_W-1:0] w_rpt_lim;
    logic             w_rpt_fire;

    always_comb begin
        w_rpt_hold = w_same && ((KEY == K_UP) || (KEY == K_DOWN))
                     && (r_cnt == CNT_W'(DEBOUNCE_CYC)) && (r_state == ST_EDIT);
        w_rpt_lim  = r_rpt_first ? RPT_W'(REPEAT_DLY) : RPT_W'(REPEAT_RATE);
        w_rpt_fire = w_rpt_hold && ((r_rpt + RPT_W'(1)) == w_rpt_lim);
        w_fire     = w_press || w_rpt_fire;
    end

    always_ff @(posedge CLK) begin
        if (RESET || !w_rpt_hold) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_fire) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt       <= r_rpt + RPT_W'(1);
        end
    end
`else
    always_comb w_fire = w_press;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_code    <= '0;
            r_cnt     <= '0;
            r_evt     <= 1'b0;
            r_evt_key <= '0;
        end else begin
            r_code    <= KEY;
            r_cnt     <= w_cnt_nxt;
            r_evt     <= w_fire;
            r_evt_key <= KEY;
        end
    end

    always_comb begin
        w_cur = r_out[r_sel*FW +: FW];
        w_min = MIN_VAL[r_sel*FW +: FW];
        w_max = MAX_VAL[r_sel*FW +: FW];
        w_up  = (w_cur >= w_max) ? w_min : w_cur + FW'(1);
        w_dn  = ((w_cur <= w_min) || (w_cur > w_max)) ? w_max : w_cur - FW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_out    <= '0;
            r_sel    <= '0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_out <= IN_VAL;
                    if (r_evt && (r_evt_key == K_SET)) begin
                        r_state <= ST_EDIT;
                        r_sel   <= '0;
                    end
                end
                ST_EDIT: begin
                    if (r_evt) begin
                        case (r_evt_key)
                            K_MENU:   r_sel <= (r_sel == FSW'(NFIELD - 1)) ? '0 : r_sel + FSW'(1);
                            K_UP:     r_out[r_sel*FW +: FW] <= w_up;
                            K_DOWN:   r_out[r_sel*FW +: FW] <= w_dn;
                            K_SET: begin
                                r_commit <= 1'b1;
                                r_state  <= ST_IDLE;
                            end
                            K_CANCEL: r_state <= ST_IDLE;
                            default:  ;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign OUT_VAL   = r_out;
    assign FIELD_SEL = r_sel;
    assign EDITING   = (r_state == ST_EDIT);
    assign COMMIT    = r_commit;
endmodule

// File: tb/tb_key_field_editor.sv
// Directed bench for key_field_editor with DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_RATE=5.
module tb_key_field_editor;
    localparam int NFIELD = 3;
    localparam int FW     = 7;
    localparam int FSW    = 2;
    localparam int DEB    = 4;
    localparam int DW     = NFIELD * FW;

    localparam logic [4:0] K_MENU   = 5'b10000;
    localparam logic [4:0] K_SET    = 5'b01000;
    localparam logic [4:0] K_CANCEL = 5'b00100;
    localparam logic [4:0] K_UP     = 5'b00010;
    localparam logic [4:0] K_DOWN   = 5'b00001;

`ifdef KEY_FIELD_EDITOR_REPEAT_EN
    localparam int N_UP_EVT = 4;
`else
    localparam int N_UP_EVT = 1;
`endif

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [4:0]     KEY = '0;
    logic [DW-1:0]  IN_VAL, MIN_VAL, MAX_VAL, OUT_VAL;
    logic [FSW-1:0] FIELD_SEL;
    logic           EDITING, COMMIT;

    int n_vec    = 0;
    int n_err    = 0;
    int n_commit = 0;

    key_field_editor #(
        .NFIELD(NFIELD), .FW(FW), .FSW(FSW),
        .DEBOUNCE_CYC(DEB), .REPEAT_DLY(10), .REPEAT_RATE(5)
    ) dut (
        .CLK(CLK), .RESET(RESET), .KEY(KEY),
        .IN_VAL(IN_VAL), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
        .OUT_VAL(OUT_VAL), .FIELD_SEL(FIELD_SEL), .EDITING(EDITING), .COMMIT(COMMIT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (COMMIT === 1'b1) n_commit++;

    function automatic logic [DW-1:0] pack(input int f0, input int f1, input int f2);
        return {FW'(f2), FW'(f1), FW'(f0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic hold_key(input logic [4:0] k, input int n);
        KEY = k;
        tick(n);
        KEY = '0;
    endtask

    // Accept one press, then leave one released cycle so the effect is visible.
    task automatic press(input logic [4:0] k);
        hold_key(k, DEB);
        tick(1);
    endtask

    initial begin
        IN_VAL  = pack(23, 5, 100);
        MIN_VAL = pack(0, 0, 10);
        MAX_VAL = pack(23, 50, 120);
        tick(2);
        check("rst_out",     32'(OUT_VAL), 32'(0));
        check("rst_sel",     32'(FIELD_SEL), 32'(0));
        check("rst_editing", 32'(EDITING), 32'(0));
        check("rst_commit",  32'(COMMIT), 32'(0));

        RESET = 1'b0;
        tick(1);
        check("idle_track", 32'(OUT_VAL), 32'(pack(23, 5, 100)));

        hold_key(K_SET, 3);
        tick(2);
        check("set_3cyc", 32'(EDITING), 32'(0));

        hold_key(K_SET, 4);
        check("set_edge4", 32'(EDITING), 32'(0));
        tick(1);
        check("set_edge5", 32'(EDITING), 32'(1));
        check("set_sel0",  32'(FIELD_SEL), 32'(0));

        IN_VAL = pack(1, 2, 3);
        tick(1);
        check("in_frozen", 32'(OUT_VAL), 32'(pack(23, 5, 100)));

        press(K_UP);
        check("up_wrap", 32'(OUT_VAL), 32'(pack(0, 5, 100)));
        press(K_DOWN);
        check("down_wrap", 32'(OUT_VAL), 32'(pack(23, 5, 100)));

        press(K_MENU);
        check("menu_1", 32'(FIELD_SEL), 32'(1));
        press(K_MENU);
        check("menu_2", 32'(FIELD_SEL), 32'(2));
        press(K_MENU);
        check("menu_0", 32'(FIELD_SEL), 32'(0));

        press(K_MENU);
        press(K_UP);
        press(K_UP);
        check("f1_edit", 32'(OUT_VAL), 32'(pack(23, 7, 100)));

        hold_key(K_SET, 4);
        tick(1);
        check("commit_hi",   32'(COMMIT), 32'(1));
        check("commit_out",  32'(OUT_VAL), 32'(pack(23, 7, 100)));
        check("commit_idle", 32'(EDITING), 32'(0));
        tick(1);
        check("commit_lo",   32'(COMMIT), 32'(0));
        check("commit_track", 32'(OUT_VAL), 32'(pack(1, 2, 3)));

        IN_VAL = pack(23, 5, 100);
        press(K_SET);
        press(K_MENU);
        press(K_UP);
        press(K_UP);
        check("cancel_pre", 32'(OUT_VAL), 32'(pack(23, 7, 100)));
        hold_key(K_CANCEL, 4);
        tick(1);
        check("cancel_idle",   32'(EDITING), 32'(0));
        check("cancel_commit", 32'(COMMIT), 32'(0));
        tick(1);
        check("cancel_track", 32'(OUT_VAL), 32'(pack(23, 5, 100)));

        // 28 held cycles: events on cycles 4, 14, 19, 24 when repeat is enabled.
        IN_VAL = pack(23, 5, 125);
        tick(1);
        press(K_SET);
        press(K_MENU);
        hold_key(K_UP, 28);
        tick(1);
        check("up_held", 32'(OUT_VAL), 32'(pack(23, 5 + N_UP_EVT, 125)));
        tick(12);
        check("up_released", 32'(OUT_VAL), 32'(pack(23, 5 + N_UP_EVT, 125)));

        press(K_MENU);
        press(K_DOWN);
        check("down_above_max", 32'(OUT_VAL), 32'(pack(23, 5 + N_UP_EVT, 120)));
        press(K_DOWN);
        check("down_step", 32'(OUT_VAL), 32'(pack(23, 5 + N_UP_EVT, 119)));

        KEY   = K_UP;
        RESET = 1'b1;
        tick(1);
        check("midrst_out",     32'(OUT_VAL), 32'(0));
        check("midrst_sel",     32'(FIELD_SEL), 32'(0));
        check("midrst_editing", 32'(EDITING), 32'(0));
        RESET = 1'b0;
        tick(6);
        check("up_idle_ignored", 32'(EDITING), 32'(0));
        check("up_idle_track",   32'(OUT_VAL), 32'(pack(23, 5, 125)));
        KEY = '0;
        tick(2);

        KEY   = K_SET;
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(4);
        check("set_rst_edge4", 32'(EDITING), 32'(0));
        tick(1);
        check("set_rst_edge5", 32'(EDITING), 32'(1));
        KEY = '0;
        tick(2);

        check("commit_count", 32'(n_commit), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
